// File: rtl/usrt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usrt_pkg
// Purpose : USRT link definitions shared by the transmitter and receiver.
// Rev     : 1.0
// ============================================================================
package usrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } usrt_state_e;

  localparam int USRT_DW      = 8;
  localparam bit USRT_PAR_ODD = 1'b0;

  // Bit-counter width; a one-bit word still needs a one-bit counter.
  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usrt_rx_cntr.sv
`default_nettype none
// ============================================================================
// Module  : usrt_rx_cntr
// Purpose : Data-bit counter of the USRT receiver; flags the last data bit.
// Rev     : 1.0
// ============================================================================
module usrt_rx_cntr
  import usrt_pkg::*;
#(
  parameter int DW = USRT_DW
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic max
);

  localparam int            CW      = cnt_width(DW);
  localparam logic [CW-1:0] CNT_MAX = CW'(DW - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign max = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/usrt_rx.sv
`default_nettype none
// ============================================================================
// Module  : usrt_rx
// Purpose : USRT receiver: strobe-timed frame deserialiser with a one-word
//           holding register, valid/rd handshake and RTS flow control.
// Rev     : 1.0
// ============================================================================
module usrt_rx
  import usrt_pkg::*;
#(
  parameter int DW      = USRT_DW,
  parameter bit PAR_ODD = USRT_PAR_ODD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_usrt,
  input  logic          rxd,
  input  logic          par_en,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          par_err,
  output logic          frm_err,
  output logic          overrun,
  output logic          busy,
  output logic          RTS
);

  usrt_state_e   state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          rpar_q, rpar_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          load_q, load_d;

  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          par_err_q, par_err_d;
  logic          frm_err_q, frm_err_d;
  logic          overrun_q, overrun_d;

  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_max;
  logic [DW-1:0] shreg_shift;

  usrt_rx_cntr #(
    .DW (DW)
  ) u_cntr (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .max (cnt_max)
  );

  // Right shift: the first (LSB) data bit ends up in bit 0.
  generate
    if (DW == 1) begin : g_shift_one
      assign shreg_shift = rxd;
    end else begin : g_shift_multi
      assign shreg_shift = {rxd, shreg_q[DW-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    rpar_d  = rpar_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    load_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (en_usrt) begin
      case (state_q)
        IDLE: begin
          if (!rxd) begin
            state_d = DATA;
            cnt_clr = 1'b1;
            par_d   = par_en;
            rpar_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end
        DATA: begin
          shreg_d = shreg_shift;
          rpar_d  = rpar_q ^ rxd;
          cnt_en  = 1'b1;
          if (cnt_max) begin
            state_d = par_q ? PAR : STOP;
          end
        end
        PAR: begin
          perr_d  = rpar_q ^ rxd ^ PAR_ODD;
          state_d = STOP;
        end
        STOP: begin
          ferr_d  = ~rxd;
          load_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Holding register: a load may be accepted in the same cycle the consumer reads.
  always_comb begin
    dout_d    = dout_q;
    valid_d   = valid_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    overrun_d = overrun_q;
    if (load_q) begin
      if (!valid_q || rd) begin
        dout_d    = shreg_q;
        par_err_d = perr_q;
        frm_err_d = ferr_q;
        valid_d   = 1'b1;
        if (rd) begin
          overrun_d = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      rpar_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      load_q    <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      rpar_q    <= rpar_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      load_q    <= load_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout    = dout_q;
  assign valid   = valid_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);
  assign RTS     = ~valid_q;

endmodule
`default_nettype wire

// File: tb/tb_usrt_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_usrt_rx
// Purpose : Scoreboard bench for usrt_rx with directed frames.
// Rev     : 1.0
// ============================================================================
module tb_usrt_rx;

  localparam int DW      = 8;
  localparam bit PAR_ODD = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_usrt;
  logic          rxd;
  logic          par_en;
  logic          rd;
  logic [DW-1:0] dout;
  logic          valid;
  logic          par_err;
  logic          frm_err;
  logic          overrun;
  logic          busy;
  logic          RTS;

  usrt_rx #(
    .DW      (DW),
    .PAR_ODD (PAR_ODD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en_usrt (en_usrt),
    .rxd     (rxd),
    .par_en  (par_en),
    .rd      (rd),
    .dout    (dout),
    .valid   (valid),
    .par_err (par_err),
    .frm_err (frm_err),
    .overrun (overrun),
    .busy    (busy),
    .RTS     (RTS)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a new word is presented when valid rises or the held word changes.
  logic          valid_prev = 1'b0;
  logic [DW+1:0] word_prev  = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid === 1'b1 &&
        (!valid_prev || {dout, par_err, frm_err} != word_prev)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got dout=0x%0h, expected no new word", dout);
      end else begin
        e = exp_q.pop_front();
        check("sb_dout", 32'(dout), 32'(e.data));
        check("sb_par_err", 32'(par_err), 32'(e.perr));
        check("sb_frm_err", 32'(frm_err), 32'(e.ferr));
      end
    end
    valid_prev = valid;
    word_prev  = {dout, par_err, frm_err};
  end

  task automatic strobe(input logic b);
    @(negedge clk);
    rxd     = b;
    en_usrt = 1'b1;
    @(negedge clk);
    en_usrt = 1'b0;
  endtask

  task automatic freeze(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rxd = k[0];
    end
    check("busy_frozen", 32'(busy), 32'd1);
    check("valid_frozen", 32'(valid), 32'd0);
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic pbit,
                            input logic stopb, input logic push, input logic eperr,
                            input logic eferr, input logic lat_chk, input logic rd_in_load,
                            input int freeze_at);
    exp_t e;
    par_en = pen;
    strobe(1'b0);
    par_en = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (i == freeze_at) freeze(50);
      strobe(data[i]);
    end
    if (pen) strobe(pbit);
    if (push) begin
      e.data = data;
      e.perr = eperr;
      e.ferr = eferr;
      exp_q.push_back(e);
    end
    strobe(stopb);
    check("busy_after_stop", 32'(busy), 32'd0);
    if (lat_chk) check("valid_before_load", 32'(valid), 32'd0);
    if (rd_in_load) rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (lat_chk) begin
      check("valid_after_load", 32'(valid), 32'd1);
      check("rts_after_load", 32'(RTS), 32'd0);
    end
  endtask

  task automatic do_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("valid_after_rd", 32'(valid), 32'd0);
    check("rts_after_rd", 32'(RTS), 32'd1);
    check("overrun_after_rd", 32'(overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    en_usrt = 1'b0;
    rxd     = 1'b1;
    par_en  = 1'b0;
    rd      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_rts", 32'(RTS), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_flags", 32'({par_err, frm_err}), 32'd0);
    rst = 1'b0;

    // Plain frame, no parity
    send_frame(8'h3C, 0, 0, 1, 1, 0, 0, 1, 0, -1);
    check("dout_3c", 32'(dout), 32'h3C);
    do_rd();

    // Even parity: good then bad
    send_frame(8'hA5, 1, 0, 1, 1, 0, 0, 1, 0, -1);
    check("par_err_a5", 32'(par_err), 32'd0);
    do_rd();
    send_frame(8'h01, 1, 0, 1, 1, 1, 0, 1, 0, -1);
    check("par_err_01", 32'(par_err), 32'd1);
    do_rd();
    check("par_err_held", 32'(par_err), 32'd1);

    // Framing error followed by a clean frame
    send_frame(8'h55, 0, 0, 0, 1, 0, 1, 1, 0, -1);
    check("frm_err_55", 32'(frm_err), 32'd1);
    do_rd();
    send_frame(8'h0F, 0, 0, 1, 1, 0, 0, 1, 0, -1);
    check("frm_err_0f", 32'(frm_err), 32'd0);
    do_rd();

    // Overrun: second word dropped
    send_frame(8'h11, 0, 0, 1, 1, 0, 0, 1, 0, -1);
    send_frame(8'h22, 0, 0, 1, 0, 0, 0, 0, 0, -1);
    check("ovr_dout_kept", 32'(dout), 32'h11);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(valid), 32'd1);
    do_rd();

    // rd in the load cycle accepts the new word
    send_frame(8'h11, 0, 0, 1, 1, 0, 0, 1, 0, -1);
    send_frame(8'h22, 0, 0, 1, 1, 0, 0, 0, 1, -1);
    check("rdload_dout", 32'(dout), 32'h22);
    check("rdload_overrun", 32'(overrun), 32'd0);
    check("rdload_valid", 32'(valid), 32'd1);
    do_rd();

    // Async reset mid-frame while a word is held
    send_frame(8'hFF, 0, 0, 0, 1, 0, 1, 1, 0, -1);
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    check("busy_midframe", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_dout", 32'(dout), 32'd0);
    check("arst_frm_err", 32'(frm_err), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rts", 32'(RTS), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h81, 0, 0, 1, 1, 0, 0, 1, 0, -1);
    check("dout_81", 32'(dout), 32'h81);
    do_rd();

    // Strobe freeze mid-frame
    send_frame(8'h96, 0, 0, 1, 1, 0, 0, 1, 0, 3);
    check("dout_96", 32'(dout), 32'h96);
    do_rd();

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
